// File: rtl/ex_stage_if.sv
// ID/EX -> EX/MEM boundary bundle for the execute stage.
// master drives the decoded slot and observes the registered EX/MEM outputs.
interface ex_stage_if;
    logic        valid_ID_EX;
    logic        read_data_valid_ID_EX;
    logic [3:0]  alu_ctrl_ID_EX;
    logic [31:0] immOut_ID_EX;
    logic [31:0] Read1_ID_EX;
    logic [31:0] Read2_ID_EX;
    logic [4:0]  rd_ID_EX;
    logic [2:0]  func3_ID_EX;
    logic [6:0]  opcode_ID_EX;
    logic [31:0] PC_ID_ID_EX;

    logic        valid_EX_MEM;
    logic [31:0] alu_result_EX_MEM;
    logic [31:0] store_data_EX_MEM;
    logic [4:0]  rd_EX_MEM;
    logic [2:0]  func3_EX_MEM;
    logic [6:0]  opcode_EX_MEM;
    logic        read_data_valid_EX_MEM;
    logic        redirect_EX_MEM;
    logic [31:0] target_EX_MEM;

    modport master (
        output valid_ID_EX, read_data_valid_ID_EX, alu_ctrl_ID_EX, immOut_ID_EX,
               Read1_ID_EX, Read2_ID_EX, rd_ID_EX, func3_ID_EX, opcode_ID_EX, PC_ID_ID_EX,
        input  valid_EX_MEM, alu_result_EX_MEM, store_data_EX_MEM, rd_EX_MEM, func3_EX_MEM,
               opcode_EX_MEM, read_data_valid_EX_MEM, redirect_EX_MEM, target_EX_MEM
    );

    modport slave (
        input  valid_ID_EX, read_data_valid_ID_EX, alu_ctrl_ID_EX, immOut_ID_EX,
               Read1_ID_EX, Read2_ID_EX, rd_ID_EX, func3_ID_EX, opcode_ID_EX, PC_ID_ID_EX,
        output valid_EX_MEM, alu_result_EX_MEM, store_data_EX_MEM, rd_EX_MEM, func3_EX_MEM,
               opcode_EX_MEM, read_data_valid_EX_MEM, redirect_EX_MEM, target_EX_MEM
    );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, branch/jump resolution, wrong-path squash and the EX/MEM register.
module ex_stage #(
    parameter int unsigned SHADOW = 2
) (
    input logic       clk,
    input logic       rst,
    input logic       stall,
    ex_stage_if.slave bus
);

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [1:0] ShadowCnt = 2'(SHADOW);

    logic [31:0] op_a, op_b, imm, pc;
    logic [4:0]  shamt;
    logic [31:0] alu_out, result, target, jalr_sum;
    logic        cond, taken, effective;

    logic        valid_q, rdv_q, redirect_q;
    logic [31:0] result_q, store_q, target_q;
    logic [4:0]  rd_q;
    logic [2:0]  func3_q;
    logic [6:0]  opcode_q;
    logic [1:0]  sqz_q;

    assign op_a  = bus.Read1_ID_EX;
    assign imm   = bus.immOut_ID_EX;
    assign pc    = bus.PC_ID_ID_EX;
    assign op_b  = (bus.opcode_ID_EX == OpReg || bus.opcode_ID_EX == OpBranch) ?
                   bus.Read2_ID_EX : imm;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_out = 32'd0;
        case (bus.alu_ctrl_ID_EX)
            4'd0:    alu_out = op_a + op_b;
            4'd1:    alu_out = op_a - op_b;
            4'd2:    alu_out = op_a << shamt;
            4'd3:    alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
            4'd4:    alu_out = {31'd0, op_a < op_b};
            4'd5:    alu_out = op_a ^ op_b;
            4'd6:    alu_out = op_a >> shamt;
            4'd7:    alu_out = $signed(op_a) >>> shamt;
            4'd8:    alu_out = op_a | op_b;
            4'd9:    alu_out = op_a & op_b;
            default: alu_out = 32'd0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (bus.func3_ID_EX)
            3'b000:  cond = (bus.Read1_ID_EX == bus.Read2_ID_EX);
            3'b001:  cond = (bus.Read1_ID_EX != bus.Read2_ID_EX);
            3'b100:  cond = ($signed(bus.Read1_ID_EX) <  $signed(bus.Read2_ID_EX));
            3'b101:  cond = ($signed(bus.Read1_ID_EX) >= $signed(bus.Read2_ID_EX));
            3'b110:  cond = (bus.Read1_ID_EX <  bus.Read2_ID_EX);
            3'b111:  cond = (bus.Read1_ID_EX >= bus.Read2_ID_EX);
            default: cond = 1'b0;
        endcase
    end

    assign jalr_sum = bus.Read1_ID_EX + imm;

    always_comb begin
        result = alu_out;
        target = pc + imm;
        taken  = 1'b0;
        case (bus.opcode_ID_EX)
            OpLui:    result = imm;
            OpAuipc:  result = pc + imm;
            OpJal: begin
                result = pc + 32'd4;
                taken  = 1'b1;
            end
            OpJalr: begin
                result = pc + 32'd4;
                target = jalr_sum & ~32'd1;
                taken  = 1'b1;
            end
            OpBranch: taken = cond;
            default:  result = alu_out;
        endcase
    end

    // Slots in the shadow of a taken redirect are wrong-path and become bubbles.
    assign effective = bus.valid_ID_EX && (sqz_q == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rdv_q      <= 1'b0;
            redirect_q <= 1'b0;
            result_q   <= 32'd0;
            store_q    <= 32'd0;
            target_q   <= 32'd0;
            rd_q       <= 5'd0;
            func3_q    <= 3'd0;
            opcode_q   <= 7'd0;
            sqz_q      <= 2'd0;
        end else if (stall) begin
            // Everything holds except the redirect, which must stay a single pulse.
            redirect_q <= 1'b0;
        end else begin
            if (effective) begin
                valid_q    <= 1'b1;
                rdv_q      <= bus.read_data_valid_ID_EX;
                redirect_q <= taken;
                result_q   <= result;
                store_q    <= bus.Read2_ID_EX;
                target_q   <= taken ? target : 32'd0;
                rd_q       <= bus.rd_ID_EX;
                func3_q    <= bus.func3_ID_EX;
                opcode_q   <= bus.opcode_ID_EX;
            end else begin
                valid_q    <= 1'b0;
                rdv_q      <= 1'b0;
                redirect_q <= 1'b0;
                result_q   <= 32'd0;
                store_q    <= 32'd0;
                target_q   <= 32'd0;
                rd_q       <= 5'd0;
                func3_q    <= 3'd0;
                opcode_q   <= 7'd0;
            end
            if (effective && taken) begin
                sqz_q <= ShadowCnt;
            end else if (sqz_q != 2'd0) begin
                sqz_q <= sqz_q - 2'd1;
            end
        end
    end

    assign bus.valid_EX_MEM           = valid_q;
    assign bus.read_data_valid_EX_MEM = rdv_q;
    assign bus.redirect_EX_MEM        = redirect_q;
    assign bus.alu_result_EX_MEM      = result_q;
    assign bus.store_data_EX_MEM      = store_q;
    assign bus.target_EX_MEM          = target_q;
    assign bus.rd_EX_MEM              = rd_q;
    assign bus.func3_EX_MEM           = func3_q;
    assign bus.opcode_EX_MEM          = opcode_q;

endmodule
